// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch front end.
// The packed entry layout fixes the queue widths to INSTRUCTION_LEN/ADDRESS_LEN.
`timescale 1ns/1ps
package fetch_queue_pkg;

  localparam int INSTRUCTION_LEN = 19;
  localparam int ADDRESS_LEN     = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTRUCTION_LEN-1:0] instr;
    logic [ADDRESS_LEN-1:0]     pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push and pop.
// head reads as zero while empty so decode never sees stale words.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 push_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, talks req/ack to instruction memory and
// buffers fetched words for decode. Optional counters under FETCH_QUEUE_STATS_EN.
`timescale 1ns/1ps
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int INSTR_W = INSTRUCTION_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc_plus1,
  input  logic               instr_ready
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]        stat_starve,
  output logic [15:0]        stat_redirects
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] kill_addr_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              slot_ok;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  assign pc_inc      = fetch_pc_reg + ADDR_W'(1);
  assign instr_valid = !empty && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state_reg == REQ) && imem_ack && !redirect_valid;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);
  // Without a push the count can only fall, so a free slot means "not full, or popping".
  assign slot_ok     = push ? (count_next < CNT_W'(DEPTH)) : (!full || pop);

  assign push_data.instr    = imem_data;
  assign push_data.pc_plus1 = pc_inc;
  assign instr              = head.instr;
  assign instr_pc_plus1     = head.pc_plus1;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A KILL completes on its ack even if a new redirect lands the same cycle;
  // fetch_pc already holds the latest target so REQ resumes there.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (redirect_valid || slot_ok) state_next = REQ;
      REQ: begin
        if (redirect_valid)  state_next = imem_ack ? REQ : KILL;
        else if (imem_ack)   state_next = slot_ok ? REQ : IDLE;
      end
      KILL: if (imem_ack) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_reg != IDLE);
    imem_addr = (state_reg == KILL) ? kill_addr_reg : fetch_pc_reg;
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) fetch_pc_next = redirect_pc;
    else if (push)      fetch_pc_next = pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg  <= '0;
      kill_addr_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      if (state_reg == REQ && redirect_valid && !imem_ack) kill_addr_reg <= fetch_pc_reg;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] starve_reg;
  logic [15:0] redirects_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_reg    <= '0;
      redirects_reg <= '0;
    end else begin
      if (instr_ready && !instr_valid && starve_reg != 16'hFFFF)
        starve_reg <= starve_reg + 16'd1;
      if (redirect_valid && redirects_reg != 16'hFFFF)
        redirects_reg <= redirects_reg + 16'd1;
    end
  end

  assign stat_starve    = starve_reg;
  assign stat_redirects = redirects_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model
// of the fetch rules plus a latency-programmable instruction memory.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_data;
  logic        instr_valid;
  logic [18:0] instr;
  logic [11:0] instr_pc_plus1;
  logic        instr_ready;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stat_starve;
  logic [15:0] stat_redirects;
`endif

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(12), .INSTR_W(19)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc_plus1 (instr_pc_plus1),
    .instr_ready    (instr_ready)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_starve    (stat_starve),
    .stat_redirects (stat_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] word;
    logic [11:0] pp1;
  } mentry_t;

  // Model state: queued entries, fetch PC, and the single outstanding request.
  mentry_t     mq[$];
  logic [11:0] m_pc;
  logic        m_out;
  logic        m_kill;
  logic [11:0] m_out_addr;
  int          m_starve;
  int          m_redir;

  int mem_lat;
  int mem_wait;
  bit rand_lat;

  int total;
  int bad;

  logic        obs_req, obs_valid, obs_ack;
  logic [11:0] obs_addr, obs_pp1;
  int          obs_starve, obs_redir;

  function automatic logic [18:0] data_of(input logic [11:0] a);
    return {a[6:0] ^ 7'h5b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc_plus1", 32'(instr_pc_plus1), 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    check("rst_stat_starve", 32'(stat_starve), 32'd0);
    check("rst_stat_redirects", 32'(stat_redirects), 32'd0);
`endif
    mq.delete();
    m_pc = '0; m_out = 1'b0; m_kill = 1'b0; m_out_addr = '0;
    m_starve = 0; m_redir = 0; mem_wait = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance the model.
  task automatic cycle(input logic rd, input logic [11:0] rpc, input logic rdy);
    logic        ack_v;
    logic        exp_valid;
    logic        pop_m;
    mentry_t     e;
    redirect_valid = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    ack_v = 1'b0;
    if (imem_req) begin
      if (mem_wait >= mem_lat) begin
        ack_v = 1'b1;
        mem_wait = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
    imem_ack = ack_v;
    imem_data = ack_v ? data_of(imem_addr) : 19'h0;
    #1;
    exp_valid = (mq.size() > 0) && !rd;
    check("imem_req", 32'(imem_req), 32'(m_out));
    if (m_out) check("imem_addr", 32'(imem_addr), 32'(m_out_addr));
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("instr", 32'(instr), 32'(mq[0].word));
      check("instr_pc_plus1", 32'(instr_pc_plus1), 32'(mq[0].pp1));
    end
`ifdef FETCH_QUEUE_STATS_EN
    check("stat_starve", 32'(stat_starve), 32'(m_starve));
    check("stat_redirects", 32'(stat_redirects), 32'(m_redir));
    obs_starve = int'(stat_starve);
    obs_redir = int'(stat_redirects);
    if (rdy && !exp_valid && m_starve < 65535) m_starve++;
    if (rd && m_redir < 65535) m_redir++;
`endif
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
    obs_pp1 = instr_pc_plus1; obs_ack = ack_v;

    pop_m = exp_valid && rdy;
    if (pop_m) $display("pop pc_plus1=%03h instr=%05h", instr_pc_plus1, instr);
    if (rd) begin
      mq.delete();
      m_pc = rpc;
      if (m_out && !ack_v) begin
        m_kill = 1'b1;
      end else begin
        m_out = 1'b1; m_kill = 1'b0; m_out_addr = rpc;
      end
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (m_out && ack_v) begin
        if (!m_kill) begin
          e.word = data_of(m_out_addr);
          e.pp1 = m_out_addr + 12'd1;
          mq.push_back(e);
          m_pc = m_pc + 12'd1;
        end
        m_out = 1'b0; m_kill = 1'b0;
      end
      if (!m_out && mq.size() < DEPTH) begin
        m_out = 1'b1; m_out_addr = m_pc;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks;
    logic rd;
    logic rdy;
    logic [11:0] rpc;
    total = 0; bad = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    mem_lat = 0; mem_wait = 0; rand_lat = 1'b0;
    @(negedge clk);

    // Zero-wait streaming, one instruction per cycle from cycle 2.
    do_reset();
    mem_lat = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 12'h0, 1'b1);
      if (k == 1) begin
        check("a_first_req", 32'(obs_req), 32'd1);
        check("a_first_addr", 32'(obs_addr), 32'd0);
      end
      if (k >= 2) begin
        check("a_valid", 32'(obs_valid), 32'd1);
        check("a_pc_plus1", 32'(obs_pp1), 32'(k - 1));
      end
    end

    // Decode stalled: exactly DEPTH fetches, then one pop re-issues at PC 4.
    do_reset();
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 12'h0, 1'b0);
      acks += int'(obs_ack);
    end
    check("b_ack_count", 32'(acks), 32'd4);
    check("b_req_dropped", 32'(obs_req), 32'd0);
    cycle(1'b0, 12'h0, 1'b1);
    check("b_pop_valid", 32'(obs_valid), 32'd1);
    check("b_pop_pp1", 32'(obs_pp1), 32'd1);
    cycle(1'b0, 12'h0, 1'b0);
    check("b_reissue_req", 32'(obs_req), 32'd1);
    check("b_reissue_addr", 32'(obs_addr), 32'd4);

    // Redirect during a 3-cycle wait: old address held, its data dropped.
    do_reset();
    mem_lat = 3;
    for (int k = 0; k < 12; k++) begin
      cycle(k == 2, 12'h100, 1'b1);
      if (k == 3 || k == 4) begin
        check("c_kill_req", 32'(obs_req), 32'd1);
        check("c_kill_addr", 32'(obs_addr), 32'd0);
      end
      if (k == 4) check("c_kill_ack", 32'(obs_ack), 32'd1);
      if (k == 5) check("c_new_addr", 32'(obs_addr), 32'h100);
      if (k >= 3 && k <= 8) check("c_discard", 32'(obs_valid), 32'd0);
      if (k == 9) begin
        check("c_first_valid", 32'(obs_valid), 32'd1);
        check("c_first_pp1", 32'(obs_pp1), 32'h101);
      end
    end

    // Redirect to the top of the address space wraps to zero.
    do_reset();
    mem_lat = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(k == 0, 12'hFFF, 1'b1);
      if (k == 1) check("d_addr_fff", 32'(obs_addr), 32'hFFF);
      if (k == 2) check("d_pp1_000", 32'(obs_pp1), 32'h000);
      if (k == 3) check("d_pp1_001", 32'(obs_pp1), 32'h001);
    end

    // Redirect together with an ack and a pop on a busy queue.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, 12'h0, 1'b0);
    cycle(1'b0, 12'h0, 1'b1);
    cycle(1'b1, 12'h200, 1'b1);
    check("e_valid_in_redirect", 32'(obs_valid), 32'd0);
    check("e_ack_in_redirect", 32'(obs_ack), 32'd1);
    cycle(1'b0, 12'h0, 1'b0);
    check("e_empty_after", 32'(obs_valid), 32'd0);
    check("e_req_target", 32'(obs_addr), 32'h200);
    cycle(1'b0, 12'h0, 1'b0);
    check("e_target_valid", 32'(obs_valid), 32'd1);
    check("e_target_pp1", 32'(obs_pp1), 32'h201);

`ifdef FETCH_QUEUE_STATS_EN
    do_reset();
    mem_lat = 3;
    for (int k = 0; k < 5; k++) cycle(1'b0, 12'h0, 1'b1);
    cycle(1'b1, 12'h040, 1'b0);
    cycle(1'b1, 12'h041, 1'b0);
    cycle(1'b0, 12'h0, 1'b0);
    check("s_starve_5", 32'(obs_starve), 32'd5);
    check("s_redirects_2", 32'(obs_redir), 32'd2);
`endif

    // Random traffic with random memory latency and a mid-run reset.
    do_reset();
    rand_lat = 1'b1;
    mem_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rd = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cycle(rd, rpc, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
